// File: rtl/mult8_pkg.sv
// mult8_pkg: definitions shared by the 8-bit multiplier dispatcher slice.
//   disp_state_t          - dispatcher FSM states (IDLE, ISSUE, WAIT, CLEAR)
//   MULT8_OPW             - operand width
//   MULT8_RESW            - product width
//   MULT8_TIMEOUT_DEFAULT - default WAIT-state cycle limit
package mult8_pkg;

  localparam int unsigned MULT8_OPW             = 8;
  localparam int unsigned MULT8_RESW            = 16;
  localparam int unsigned MULT8_TIMEOUT_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_CLEAR = 2'd3
  } disp_state_t;

endpackage

// File: rtl/mult8_opfifo.sv
// mult8_opfifo: synchronous FIFO holding packed operand pairs.
// Read data is the current head (first-word fall-through); pop advances it.
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset (pointers and count to 0)
//   push   in   write wdata (ignored when full)
//   pop    in   drop head entry (ignored when empty)
//   wdata  in   WIDTH-bit entry
//   rdata  out  head entry
//   full   out  count == DEPTH
//   empty  out  count == 0
//   count  out  occupancy, $clog2(DEPTH)+1 bits
module mult8_opfifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mult8_dispatcher.sv
// mult8_dispatcher: buffers operand pairs and issues them one at a time to
// the 8-bit multiplier over its start/DONE handshake, captures each product
// in a valid/ready result register, then pulses the multiplier reset.
// Optional feature macro: MULT8_DISPATCH_TIMEOUT_EN (WAIT-state timeout abort).
// Ports:
//   clk, RESET            clock; synchronous active-high reset
//   in_valid/in_ready     producer handshake; in_x, in_y operands
//   out_valid/out_ready   consumer handshake; out_res product, out_err abort flag
//   mul_start             one-cycle start pulse to the multiplier
//   mul_x, mul_y          operands held from ISSUE until CLEAR ends
//   mul_rst               multiplier reset (RESET or CLEAR pulse)
//   mul_done, mul_res     multiplier completion and product
//   busy                  FSM not in IDLE
//   count                 operand FIFO occupancy
module mult8_dispatcher
  import mult8_pkg::*;
#(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned TIMEOUT_CYCLES = MULT8_TIMEOUT_DEFAULT
) (
  input  logic                    clk,
  input  logic                    RESET,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [MULT8_OPW-1:0]    in_x,
  input  logic [MULT8_OPW-1:0]    in_y,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [MULT8_RESW-1:0]   out_res,
  output logic                    out_err,
  output logic                    mul_start,
  output logic [MULT8_OPW-1:0]    mul_x,
  output logic [MULT8_OPW-1:0]    mul_y,
  output logic                    mul_rst,
  input  logic                    mul_done,
  input  logic [MULT8_RESW-1:0]   mul_res,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  count
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("mult8_dispatcher: DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 1");
  end

  disp_state_t                state;
  disp_state_t                state_next;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       push;
  logic                       pop;
  logic                       res_load;
  logic                       clear_pulse;
  logic                       timeout_hit;
  logic [2*MULT8_OPW-1:0]     fifo_rdata;

  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  assign busy     = (state != ST_IDLE);
  assign mul_rst  = RESET || clear_pulse;

  mult8_opfifo #(
    .DEPTH (DEPTH),
    .WIDTH (2 * MULT8_OPW)
  ) u_opfifo (
    .clk   (clk),
    .rst   (RESET),
    .push  (push),
    .pop   (pop),
    .wdata ({in_x, in_y}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Issue is gated on out_valid, which bounds pending results to one and
  // keeps results in issue order.
  always_comb begin
    state_next  = state;
    pop         = 1'b0;
    mul_start   = 1'b0;
    res_load    = 1'b0;
    clear_pulse = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty && !out_valid) begin
          pop        = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        mul_start  = 1'b1;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (mul_done || timeout_hit) begin
          res_load   = 1'b1;
          state_next = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        clear_pulse = 1'b1;
        state_next  = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      mul_x     <= '0;
      mul_y     <= '0;
      out_valid <= 1'b0;
      out_res   <= '0;
    end else begin
      if (pop) {mul_x, mul_y} <= fifo_rdata;
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (res_load) begin
        out_valid <= 1'b1;
        out_res   <= timeout_hit ? '0 : mul_res;
      end
    end
  end

`ifdef MULT8_DISPATCH_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] wait_cnt;
  logic          err_q;

  // wait_cnt is 0 in the first WAIT cycle, so the abort lands on the edge
  // that closes the TIMEOUT_CYCLES-th WAIT cycle.
  assign timeout_hit = (state == ST_WAIT) && !mul_done &&
                       (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (RESET)                 wait_cnt <= '0;
    else if (state == ST_WAIT) wait_cnt <= wait_cnt + TW'(1);
    else                       wait_cnt <= '0;
  end

  always_ff @(posedge clk) begin
    if (RESET)         err_q <= 1'b0;
    else if (res_load) err_q <= timeout_hit;
  end

  assign out_err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign out_err     = 1'b0;
`endif

endmodule

// File: tb/tb_mult8_dispatcher.sv
module tb_mult8_dispatcher;

  logic        clk = 1'b0;
  logic        RESET = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_x = '0;
  logic [7:0]  in_y = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_res;
  logic        out_err;
  logic        mul_start;
  logic [7:0]  mul_x;
  logic [7:0]  mul_y;
  logic        mul_rst;
  logic        mul_done = 1'b0;
  logic [15:0] mul_res = '0;
  logic        busy;
  logic [2:0]  count;

  int tests = 0;
  int fails = 0;

  mult8_dispatcher #(
    .DEPTH          (4),
    .TIMEOUT_CYCLES (32)
  ) dut (
    .clk       (clk),
    .RESET     (RESET),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_err   (out_err),
    .mul_start (mul_start),
    .mul_x     (mul_x),
    .mul_y     (mul_y),
    .mul_rst   (mul_rst),
    .mul_done  (mul_done),
    .mul_res   (mul_res),
    .busy      (busy),
    .count     (count)
  );

  always #5 clk = ~clk;

  // Multiplier model: done rises lat edges after start is sampled, held until mul_rst.
  int         lat = 16;
  bit         hang = 1'b0;
  logic       m_busy = 1'b0;
  int         m_cnt = 0;
  logic [7:0] m_x = '0;
  logic [7:0] m_y = '0;

  always @(posedge clk) begin
    if (mul_rst) begin
      mul_done <= 1'b0;
      mul_res  <= '0;
      m_busy   <= 1'b0;
    end else if (mul_start) begin
      m_busy <= 1'b1;
      m_cnt  <= lat;
      m_x    <= mul_x;
      m_y    <= mul_y;
    end else if (m_busy && !hang) begin
      if (m_cnt <= 1) begin
        mul_done <= 1'b1;
        mul_res  <= 16'(m_x) * 16'(m_y);
        m_busy   <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  // Event monitors.
  int          starts = 0;
  int          clr_pulses = 0;
  int          viol = 0;
  logic [15:0] res_q [$];

  always @(posedge clk) begin
    if (mul_start) starts <= starts + 1;
    if (mul_start && out_valid) viol <= viol + 1;
    if (mul_rst && !RESET) clr_pulses <= clr_pulses + 1;
    if (out_valid && out_ready && !RESET) res_q.push_back(out_res);
  end

  task automatic push_pair(input logic [7:0] x, input logic [7:0] y);
    int g = 0;
    while (!in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) begin
      tests++; fails++;
      $display("FAIL push_wait: in_ready stuck at %0b, required 1", in_ready);
    end
    in_valid = 1'b1;
    in_x = x;
    in_y = y;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out_valid(input int budget);
    int g = 0;
    while (!out_valid && g < budget) begin
      @(negedge clk);
      g++;
    end
    tests++;
    if (out_valid !== 1'b1) begin
      fails++;
      $display("FAIL out_valid_wait: out_valid=%0b after %0d cycles, required 1", out_valid, g);
    end
  endtask

  task automatic wait_results(input int n, input int budget);
    int g = 0;
    while (res_q.size() < n && g < budget) begin
      @(negedge clk);
      g++;
    end
    tests++;
    if (res_q.size() < n) begin
      fails++;
      $display("FAIL result_wait: got %0d results, required %0d", res_q.size(), n);
    end
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((busy || count != 0) && g < 500) begin
      @(negedge clk);
      g++;
    end
    tests++;
    if (busy !== 1'b0 || count !== 3'd0) begin
      fails++;
      $display("FAIL idle_wait: busy=%0b count=%0d, required 0/0", busy, count);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({count, in_ready, out_valid, out_res, out_err, mul_start, mul_x, mul_y, busy, mul_rst}
        !== {3'd0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL reset_state: cnt=%0d rdy=%0b ov=%0b res=%0d err=%0b st=%0b x=%0d y=%0d busy=%0b mrst=%0b, required 0 1 0 0 0 0 0 0 0 1",
               count, in_ready, out_valid, out_res, out_err, mul_start, mul_x, mul_y, busy, mul_rst);
    end
    RESET = 1'b0;
    @(negedge clk);
    tests++;
    if (mul_rst !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: mul_rst=%0b in_ready=%0b busy=%0b, required 0 1 0", mul_rst, in_ready, busy);
    end
  endtask

  task automatic test_single_job();
    int s0, c0;
    res_q.delete();
    lat = 16;
    out_ready = 1'b0;
    s0 = starts;
    c0 = clr_pulses;
    push_pair(8'd13, 8'd11);
    tests++;
    if (count !== 3'd1 || mul_start !== 1'b0) begin
      fails++;
      $display("FAIL single_push: count=%0d mul_start=%0b, required 1 0", count, mul_start);
    end
    @(negedge clk);
    tests++;
    if (mul_start !== 1'b1 || mul_x !== 8'd13 || mul_y !== 8'd11 || count !== 3'd0) begin
      fails++;
      $display("FAIL single_issue: start=%0b x=%0d y=%0d count=%0d, required 1 13 11 0", mul_start, mul_x, mul_y, count);
    end
    @(negedge clk);
    tests++;
    if (mul_start !== 1'b0) begin
      fails++;
      $display("FAIL single_start_pulse: mul_start=%0b, required 0", mul_start);
    end
    wait_out_valid(100);
    tests++;
    if (out_res !== 16'd143 || out_err !== 1'b0 || mul_rst !== 1'b1) begin
      fails++;
      $display("FAIL single_result: res=%0d err=%0b mul_rst=%0b, required 143 0 1", out_res, out_err, mul_rst);
    end
    @(negedge clk);
    tests++;
    if (mul_rst !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL single_clear: mul_rst=%0b busy=%0b out_valid=%0b, required 0 0 1", mul_rst, busy, out_valid);
    end
    tests++;
    if (starts - s0 !== 1 || clr_pulses - c0 !== 1) begin
      fails++;
      $display("FAIL single_pulses: starts=%0d clears=%0d, required 1 1", starts - s0, clr_pulses - c0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_consume: out_valid=%0b, required 0", out_valid);
    end
  endtask

  task automatic test_extremes();
    res_q.delete();
    lat = 5;
    out_ready = 1'b1;
    push_pair(8'd255, 8'd255);
    push_pair(8'd0, 8'd200);
    wait_results(2, 200);
    tests++;
    if (res_q.size() < 2 || res_q[0] !== 16'd65025 || res_q[1] !== 16'd0) begin
      fails++;
      $display("FAIL extremes: n=%0d r0=%0d r1=%0d, required 65025 then 0",
               res_q.size(), (res_q.size() > 0) ? res_q[0] : 16'hxxxx, (res_q.size() > 1) ? res_q[1] : 16'hxxxx);
    end
    wait_idle();
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int          s0;
    int          acc = 0;
    logic [15:0] expv [5] = '{16'd2, 16'd4, 16'd6, 16'd8, 16'd10};
    res_q.delete();
    lat = 4;
    out_ready = 1'b0;
    s0 = starts;
    for (int i = 0; i < 6; i++) begin
      in_x = 8'(i + 1);
      in_y = 8'd2;
      in_valid = 1'b1;
      if (in_ready) acc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    tests++;
    if (acc !== 5 || count !== 3'd4 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL bp_fill: accepted=%0d count=%0d in_ready=%0b, required 5 4 0", acc, count, in_ready);
    end
    wait_out_valid(100);
    repeat (40) @(negedge clk);
    tests++;
    if (starts - s0 !== 1 || count !== 3'd4 || out_valid !== 1'b1 || out_res !== 16'd2) begin
      fails++;
      $display("FAIL bp_hold: starts=%0d count=%0d out_valid=%0b res=%0d, required 1 4 1 2",
               starts - s0, count, out_valid, out_res);
    end
    out_ready = 1'b1;
    wait_results(5, 400);
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (i >= res_q.size() || res_q[i] !== expv[i]) begin
        fails++;
        $display("FAIL bp_order[%0d]: got %0d, required %0d", i, (i < res_q.size()) ? res_q[i] : 16'hxxxx, expv[i]);
      end
    end
    wait_idle();
    out_ready = 1'b0;
  endtask

  task automatic test_streaming();
    int          v0;
    logic [7:0]  xs   [8] = '{8'd1, 8'd2, 8'd15, 8'd16, 8'd100, 8'd128, 8'd200, 8'd254};
    logic [7:0]  ys   [8] = '{8'd1, 8'd3, 8'd15, 8'd16, 8'd7,   8'd2,   8'd100, 8'd3};
    logic [15:0] expv [8] = '{16'd1, 16'd6, 16'd225, 16'd256, 16'd700, 16'd256, 16'd20000, 16'd762};
    res_q.delete();
    lat = 3;
    out_ready = 1'b1;
    v0 = viol;
    for (int i = 0; i < 8; i++) push_pair(xs[i], ys[i]);
    wait_results(8, 600);
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (i >= res_q.size() || res_q[i] !== expv[i]) begin
        fails++;
        $display("FAIL stream[%0d]: got %0d, required %0d", i, (i < res_q.size()) ? res_q[i] : 16'hxxxx, expv[i]);
      end
    end
    wait_idle();
    tests++;
    if (viol - v0 !== 0) begin
      fails++;
      $display("FAIL stream_gating: %0d starts while out_valid, required 0", viol - v0);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int s0;
    res_q.delete();
    lat = 16;
    out_ready = 1'b0;
    push_pair(8'd9, 8'd9);
    push_pair(8'd3, 8'd4);
    repeat (2) @(negedge clk);
    tests++;
    if (busy !== 1'b1 || mul_done !== 1'b0) begin
      fails++;
      $display("FAIL rmid_setup: busy=%0b mul_done=%0b, required 1 0", busy, mul_done);
    end
    s0 = starts;
    RESET = 1'b1;
    #1;
    tests++;
    if (mul_rst !== 1'b1) begin
      fails++;
      $display("FAIL rmid_mul_rst: mul_rst=%0b, required 1", mul_rst);
    end
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || count !== 3'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rmid_state: out_valid=%0b count=%0d busy=%0b, required 0 0 0", out_valid, count, busy);
    end
    RESET = 1'b0;
    repeat (40) @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || res_q.size() !== 0 || starts !== s0 || mul_rst !== 1'b0) begin
      fails++;
      $display("FAIL rmid_stale: out_valid=%0b results=%0d new_starts=%0d mul_rst=%0b, required 0 0 0 0",
               out_valid, res_q.size(), starts - s0, mul_rst);
    end
  endtask

`ifdef MULT8_DISPATCH_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    res_q.delete();
    out_ready = 1'b0;
    hang = 1'b1;
    push_pair(8'd7, 8'd7);
    @(negedge clk);
    tests++;
    if (mul_start !== 1'b1) begin
      fails++;
      $display("FAIL to_issue: mul_start=%0b, required 1", mul_start);
    end
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n !== 33 || out_err !== 1'b1 || out_res !== 16'd0 || mul_rst !== 1'b1) begin
      fails++;
      $display("FAIL to_abort: cycles=%0d err=%0b res=%0d mul_rst=%0b, required 33 1 0 1", n, out_err, out_res, mul_rst);
    end
    @(negedge clk);
    tests++;
    if (mul_rst !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL to_clear: mul_rst=%0b busy=%0b, required 0 0", mul_rst, busy);
    end
    hang = 1'b0;
    lat = 4;
    out_ready = 1'b1;
    @(negedge clk);
    push_pair(8'd5, 8'd6);
    wait_results(2, 200);
    tests++;
    if (res_q.size() < 2 || res_q[1] !== 16'd30 || out_err !== 1'b0) begin
      fails++;
      $display("FAIL to_recover: res=%0d err=%0b, required 30 0", (res_q.size() > 1) ? res_q[1] : 16'hxxxx, out_err);
    end
    wait_idle();
    out_ready = 1'b0;
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_single_job();
    test_extremes();
    test_backpressure();
    test_streaming();
    test_reset_mid();
`ifdef MULT8_DISPATCH_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mult8_dispatcher.md
# mult8_dispatcher

Upstream feeder for the 8-bit multiplier control/datapath. Buffers operand pairs from a producer in a small FIFO and issues them one at a time to the multiplier via its `start`/`DONE` handshake. It captures each 16-bit product into a result register with a valid/ready output, then pulses the multiplier's reset to return it to idle before the next job. Jobs are strictly in order; at most one is in flight.

## Interface
Parameters:
- `DEPTH`, 4: operand FIFO entries; must be a power of 2 and at least 2.
- `TIMEOUT_CYCLES`, 32: WAIT-state cycle limit; used only with `MULT8_DISPATCH_TIMEOUT_EN`.

Ports:
- `clk`  in  1  sole clock; all logic on rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  producer has an operand pair.
- `in_ready`  out  1  FIFO can accept; `count < DEPTH`.
- `in_x`, `in_y`  in  8 each  unsigned operands.
- `out_valid`  out  1  result register holds an unconsumed product.
- `out_ready`  in  1  consumer accepts the result.
- `out_res`  out  16  product.
- `out_err`  out  1  result is a timeout abort; constant 0 without the macro.
- `mul_start`  out  1  one-cycle start pulse to the multiplier.
- `mul_x`, `mul_y`  out  8 each  operands, held stable from ISSUE until CLEAR ends.
- `mul_rst`  out  1  multiplier reset; equals `RESET` OR the CLEAR-state pulse.
- `mul_done`  in  1  multiplier done; held high until `mul_rst`.
- `mul_res`  in  16  product; valid while `mul_done`=1.
- `busy`  out  1  state is not IDLE.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- Push: an entry is written on any edge with `in_valid & in_ready`. When full, `in_ready`=0, so a push and a pop never coincide at full.
- FSM states: IDLE, ISSUE, WAIT, CLEAR.
  - IDLE: if `count>0` and `out_valid`=0, pop the head into `mul_x`/`mul_y` and go to ISSUE. Otherwise stay.
  - ISSUE: `mul_start`=1 for this cycle only; go to WAIT.
  - WAIT: on `mul_done`=1, load `out_res`←`mul_res`, set `out_valid`=1, `out_err`=0, and go to CLEAR.
  - CLEAR: `mul_rst`=1 for this cycle only; go to IDLE.
- Output: `out_valid` clears on the edge where `out_valid & out_ready`. `out_res` and `out_err` hold until overwritten.
- Issue gating: no new job issues while `out_valid`=1. This bounds results to one and preserves order.
- Arithmetic: the block is pass-through only. It performs no arithmetic on the product; 255×255=65025 fits in 16 bits.

## Timing
- Reset values: state IDLE; `count`=0; FIFO pointers 0; `in_ready`=1 (asserted once `RESET` deasserts); `out_valid`=0; `out_res`=0; `out_err`=0; `mul_start`=0; `mul_x`=`mul_y`=0; `busy`=0; `mul_rst`=1 while `RESET` is high.
- Job latency, with the FIFO empty and state IDLE:
  - The push edge is E0. `count`=1 after E0.
  - Pop at E1; `mul_start` is high during the E1–E2 cycle.
  - If `mul_done` is first sampled high at edge Ek, `out_valid` rises after Ek.
  - `mul_rst` pulses during the Ek–Ek+1 cycle, and the state is IDLE after Ek+1.
  - The next issue is possible at Ek+2 if the result was consumed.
- No FIFO bypass: a push into an empty FIFO is never issued in the same cycle.
- If `mul_done` is high in ISSUE, it is ignored; it is sampled only in WAIT.
- Reset mid-operation: all state returns to reset values on the next edge. A job in flight is discarded with no result, and the multiplier is reset through `mul_rst`.
- Simultaneous consume and issue: the consume at edge E clears `out_valid`; IDLE issues no earlier than edge E+1.

## Configuration
- `MULT8_DISPATCH_TIMEOUT_EN` defined:
  - A WAIT-cycle counter counts up from 0 on WAIT entry.
  - If it reaches `TIMEOUT_CYCLES` with `mul_done`=0, the block loads `out_res`=0 and `out_err`=1, sets `out_valid`=1, and goes to CLEAR.
- Not defined: no counter exists; WAIT waits indefinitely; `out_err` is tied to 0.

## Structure
- Shared package `mult8_pkg` holds:
  - The dispatcher state enum (IDLE, ISSUE, WAIT, CLEAR).
  - Constants `MULT8_OPW`=8 and `MULT8_RESW`=16.
  - The default `TIMEOUT_CYCLES`.
- One sub-module: `mult8_opfifo`, a synchronous FIFO of `DEPTH`×16 bits with push/pop, full/empty and count outputs. The dispatcher holds the FSM, operand registers and result register.

## Test plan
- Single job: push 13×11 with a multiplier model of latency 16 → exactly one `mul_start` pulse; `out_res`=143; one `mul_rst` pulse after done.
- Extremes: push 255×255, then 0×200, with `out_ready`=1 → results 65025 then 0, in order.
- Backpressure:
  - Hold `out_ready`=0 and attempt 6 pushes → `in_ready` drops after `count`=4 and the 1st entry pops.
  - Only one `mul_start` occurs until `out_ready` is raised.
- Streaming: 8 pairs with `out_ready`=1 → all 8 products in order; no `mul_start` while `out_valid`=1.
- Reset mid-WAIT: assert `RESET` for 1 cycle → `out_valid`=0, `count`=0, `mul_rst`=1 that cycle, and no stale result later.
- Timeout (macro on, `TIMEOUT_CYCLES`=32): hold `mul_done`=0 → after 32 WAIT cycles, `out_valid`=1, `out_err`=1, `out_res`=0, followed by one `mul_rst` pulse.
